id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Pipeline register between the ID and EX stages of the 5-stage core.
- Captures decoded control, register operands, immediate and register indices every cycle.
- Its Rs/Rt outputs feed the EX-stage forwarding logic and operand muxes.
- Owns load-use hazard detection and bubble insertion.
- Supports a global stall (hold), a branch flush (bubble) and a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 32, operand and immediate width.
- REG_AW, 5, register index width.
- CNT_W, 16, bubble counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- stall_i  in  1  global hold (memory stall); freezes all state.
- flush_i  in  1  branch taken in ID; inserts a bubble.
- RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i  in  1 each  decoded control from ID.
- ALUOp_i  in  2  ALU operation class.
- RegData1_i, RegData2_i  in  DATA_W  register file read data.
- Imm_i  in  DATA_W  sign-extended immediate.
- RegRs_i, RegRt_i, RegRd_i  in  REG_AW  indices of the instruction in ID.
- RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o  out  1 each  registered control.
- ALUOp_o  out  2  registered ALU operation class.
- RegData1_o, RegData2_o, Imm_o  out  DATA_W  registered data.
- RegRs_o, RegRt_o, RegRd_o  out  REG_AW  registered indices, to forwarding and write-back select.
- valid_o  out  1  1 = real instruction in EX, 0 = bubble.
- hazard_o  out  1  combinational load-use hazard flag.
- PCWrite_o  out  1  combinational; low = PC held.
- IFIDWrite_o  out  1  combinational; low = IF/ID register held.
- bubble_cnt_o  out  CNT_W  bubbles inserted since reset.

Behaviour:
- Reset (async, rst_i=1): every registered output goes to 0, including valid_o and bubble_cnt_o. Consequently hazard_o=0, PCWrite_o=1 and IFIDWrite_o=1.
- hazard_o = valid_o & MemRead_o & (RegRt_o != 0) & ((RegRt_o == RegRs_i) | (RegRt_o == RegRt_i)).
  - Depends only on registered state and current ID indices.
  - Not gated by stall_i.
- PCWrite_o = IFIDWrite_o = ~hazard_o.
- Per-edge priority:
  1. stall_i=1: all registers hold, including valid_o and bubble_cnt_o. stall_i overrides flush_i and hazard.
  2. Else if flush_i | hazard_o: bubble. All control outputs, data, indices and valid_o go to 0.
  3. Else: load. All *_i values are captured into the matching *_o; valid_o=1.
- Bubble counting: bubble_cnt_o increments by 1 on each edge taking priority 2, and saturates at all-ones (no wrap).
- Simultaneous flush_i and hazard: exactly one bubble, and the counter increments by 1.
- A hazard lasts exactly one cycle for a single load. After the bubble, valid_o=0, so hazard_o deasserts and the stalled instruction loads on the next edge.
- Latency: one cycle from ID inputs to outputs. There is no combinational path from *_i data to *_o.
- Index 0 is never treated as a hazard.
- Reset asserted mid-stall or mid-hazard: outputs clear immediately. After release, the first edge loads (no hazard possible since valid_o=0).

Decomposition:
- Shared package:
  - ALUOp encodings: 00 add, 01 sub, 10 R-type funct, 11 reserved.
  - Control-bundle struct and its zero constant CTRL_BUBBLE.
  - Register-index zero constant.
- One sub-module, load_use_detect: the combinational hazard_o / PCWrite_o / IFIDWrite_o logic.
- Pipeline register and counter stay in the parent.

Test Plan:
- Reset then load: ID presents RegWrite=1, ALUOp=10, RegData1=0x00000005, Rs=3, Rt=4, Rd=5 → after one edge the outputs match, valid_o=1, hazard_o=0.
- Load-use: EX holds MemRead=1, Rt=8, valid; ID presents Rs=8 → hazard_o=1 and PCWrite_o=0 in the same cycle. The next edge gives all outputs 0 and bubble_cnt_o=1. On the following edge the ID instruction loads, with valid_o=1.
- Zero register: EX holds MemRead=1, Rt=0; ID presents Rs=0 → hazard_o=0 and the instruction loads normally.
- Stall priority: stall_i=1 with flush_i=1 for 3 edges → outputs and bubble_cnt_o unchanged.
  - Then stall_i=0, flush_i=1 → bubble, and the counter increments by 1.
- Flush and hazard together: flush_i=1 while hazard_o=1 → single bubble, bubble_cnt_o increments by exactly 1.
- Saturation and async reset:
  - Preload bubble_cnt_o to 0xFFFF and apply a flush → the counter stays at 0xFFFF.
  - Assert rst_i between edges → all outputs read 0 before the next clock edge.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg_pkg
// Shared types and constants for the ID/EX pipeline register and its
// load-use hazard detector.
//   alu_op_e    : ALU operation class carried from decode into EX
//   ctrl_t      : decoded control bundle held in the ID/EX register
//   CTRL_BUBBLE : control bundle for an inserted bubble (all zero, no effect)
//   REG_ZERO    : register index 0, hard-wired zero, never a hazard source
// -----------------------------------------------------------------------------
package id_ex_stage_reg_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_RFUNCT = 2'b10,
        ALU_RSVD   = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    RegWrite;
        logic    MemToReg;
        logic    MemRead;
        logic    MemWrite;
        logic    ALUSrc;
        logic    RegDst;
        alu_op_e ALUOp;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        RegWrite: 1'b0,
        MemToReg: 1'b0,
        MemRead:  1'b0,
        MemWrite: 1'b0,
        ALUSrc:   1'b0,
        RegDst:   1'b0,
        ALUOp:    ALU_ADD
    };

    localparam logic [REG_AW_DEFAULT-1:0] REG_ZERO = '0;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detection. A load sitting in EX whose
// destination (Rt) matches either source index of the instruction in ID
// cannot forward in time, so the ID instruction must wait one cycle.
// Ports:
//   i_ex_valid     : EX holds a real instruction (not a bubble)
//   i_ex_memread   : EX instruction is a load
//   i_ex_rt        : destination index of the EX load
//   i_id_rs        : Rs index of the instruction in ID
//   i_id_rt        : Rt index of the instruction in ID
//   o_hazard       : load-use hazard present this cycle
//   o_pc_write     : low holds the PC
//   o_ifid_write   : low holds the IF/ID register
// -----------------------------------------------------------------------------
module load_use_detect
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    output logic              o_hazard,
    output logic              o_pc_write,
    output logic              o_ifid_write
);

    logic w_ex_rt_nonzero;
    logic w_match;

    // Register 0 reads as zero regardless of writes, so a load targeting it
    // never produces a value the ID instruction has to wait for.
    assign w_ex_rt_nonzero = (i_ex_rt != REG_AW'(REG_ZERO));
    assign w_match         = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);

    // Deliberately independent of stall: during a stall nothing advances, so
    // the flag is harmless and stays coherent with the held state.
    assign o_hazard     = i_ex_valid & i_ex_memread & w_ex_rt_nonzero & w_match;
    assign o_pc_write   = ~o_hazard;
    assign o_ifid_write = ~o_hazard;

endmodule

// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
// Pipeline register between ID and EX. Captures decoded control, operands,
// immediate and register indices every cycle, inserts bubbles on branch flush
// or load-use hazard, freezes on a global stall, and counts inserted bubbles
// with a saturating counter.
// Ports:
//   clk_i, rst_i           : clock (rising edge), async active-high reset
//   stall_i                : global hold; freezes all state
//   flush_i                : branch taken in ID; insert a bubble
//   *_i control/data/index : decoded instruction currently in ID
//   *_o control/data/index : registered instruction in EX
//   valid_o                : 1 = real instruction in EX, 0 = bubble
//   hazard_o               : combinational load-use hazard flag
//   PCWrite_o, IFIDWrite_o : combinational; low holds PC / IF-ID register
//   bubble_cnt_o           : bubbles inserted since reset (saturating)
// -----------------------------------------------------------------------------
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,

    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic              RegDst_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] RegData1_i,
    input  logic [DATA_W-1:0] RegData2_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [REG_AW-1:0] RegRs_i,
    input  logic [REG_AW-1:0] RegRt_i,
    input  logic [REG_AW-1:0] RegRd_i,

    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic              RegDst_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] RegData1_o,
    output logic [DATA_W-1:0] RegData2_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [REG_AW-1:0] RegRs_o,
    output logic [REG_AW-1:0] RegRt_o,
    output logic [REG_AW-1:0] RegRd_o,
    output logic              valid_o,
    output logic              hazard_o,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : (v + one);
    endfunction

    ctrl_t             r_ctrl;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubble_cnt;

    ctrl_t             w_ctrl_in;
    logic              w_hazard;
    logic              w_pc_write;
    logic              w_ifid_write;
    logic              w_bubble;

    assign w_ctrl_in = '{
        RegWrite: RegWrite_i,
        MemToReg: MemToReg_i,
        MemRead:  MemRead_i,
        MemWrite: MemWrite_i,
        ALUSrc:   ALUSrc_i,
        RegDst:   RegDst_i,
        ALUOp:    alu_op_e'(ALUOp_i)
    };

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .i_ex_valid   (r_valid),
        .i_ex_memread (r_ctrl.MemRead),
        .i_ex_rt      (r_rt),
        .i_id_rs      (RegRs_i),
        .i_id_rt      (RegRt_i),
        .o_hazard     (w_hazard),
        .o_pc_write   (w_pc_write),
        .o_ifid_write (w_ifid_write)
    );

    // Flush and hazard collapse into a single bubble, so a coincident pair
    // counts once.
    assign w_bubble = flush_i | w_hazard;

    // ID -> EX register boundary
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl       <= CTRL_BUBBLE;
            r_data1      <= '0;
            r_data2      <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (!stall_i) begin
            if (w_bubble) begin
                // Bubble clears data and indices too so a dead slot can never
                // match in forwarding or hazard comparisons downstream.
                r_ctrl       <= CTRL_BUBBLE;
                r_data1      <= '0;
                r_data2      <= '0;
                r_imm        <= '0;
                r_rs         <= '0;
                r_rt         <= '0;
                r_rd         <= '0;
                r_valid      <= 1'b0;
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end else begin
                r_ctrl       <= w_ctrl_in;
                r_data1      <= RegData1_i;
                r_data2      <= RegData2_i;
                r_imm        <= Imm_i;
                r_rs         <= RegRs_i;
                r_rt         <= RegRt_i;
                r_rd         <= RegRd_i;
                r_valid      <= 1'b1;
            end
        end
    end

    assign RegWrite_o   = r_ctrl.RegWrite;
    assign MemToReg_o   = r_ctrl.MemToReg;
    assign MemRead_o    = r_ctrl.MemRead;
    assign MemWrite_o   = r_ctrl.MemWrite;
    assign ALUSrc_o     = r_ctrl.ALUSrc;
    assign RegDst_o     = r_ctrl.RegDst;
    assign ALUOp_o      = r_ctrl.ALUOp;
    assign RegData1_o   = r_data1;
    assign RegData2_o   = r_data2;
    assign Imm_o        = r_imm;
    assign RegRs_o      = r_rs;
    assign RegRt_o      = r_rt;
    assign RegRd_o      = r_rd;
    assign valid_o      = r_valid;
    assign bubble_cnt_o = r_bubble_cnt;
    assign hazard_o     = w_hazard;
    assign PCWrite_o    = w_pc_write;
    assign IFIDWrite_o  = w_ifid_write;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic stall_i = 1'b0, flush_i = 1'b0;
    logic RegWrite_i = 0, MemToReg_i = 0, MemRead_i = 0, MemWrite_i = 0, ALUSrc_i = 0, RegDst_i = 0;
    logic [1:0] ALUOp_i = '0;
    logic [DATA_W-1:0] RegData1_i = '0, RegData2_i = '0, Imm_i = '0;
    logic [REG_AW-1:0] RegRs_i = '0, RegRt_i = '0, RegRd_i = '0;

    logic RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o;
    logic [1:0] ALUOp_o;
    logic [DATA_W-1:0] RegData1_o, RegData2_o, Imm_o;
    logic [REG_AW-1:0] RegRs_o, RegRt_o, RegRd_o;
    logic valid_o, hazard_o, PCWrite_o, IFIDWrite_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i),
        .ALUOp_i(ALUOp_i), .RegData1_i(RegData1_i), .RegData2_i(RegData2_i),
        .Imm_i(Imm_i), .RegRs_i(RegRs_i), .RegRt_i(RegRt_i), .RegRd_i(RegRd_i),
        .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o),
        .ALUOp_o(ALUOp_o), .RegData1_o(RegData1_o), .RegData2_o(RegData2_o),
        .Imm_o(Imm_o), .RegRs_o(RegRs_o), .RegRt_o(RegRt_o), .RegRd_o(RegRd_o),
        .valid_o(valid_o), .hazard_o(hazard_o), .PCWrite_o(PCWrite_o),
        .IFIDWrite_o(IFIDWrite_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: what EX must hold, described as one record of values
    typedef struct {
        bit  valid;
        bit  [7:0] ctrl;   // RegWrite,MemToReg,MemRead,MemWrite,ALUSrc,RegDst,ALUOp[1:0]
        longint d1, d2, imm;
        int  rs, rt, rd;
        int  cnt;
    } ex_t;

    ex_t m;

    function automatic ex_t empty_ex();
        ex_t e;
        e.valid = 0; e.ctrl = 0; e.d1 = 0; e.d2 = 0; e.imm = 0;
        e.rs = 0; e.rt = 0; e.rd = 0; e.cnt = 0;
        return e;
    endfunction

    // A load in EX blocks an ID instruction reading the register it writes
    function automatic bit model_hazard(ex_t e, int id_rs, int id_rt);
        bit is_load;
        is_load = e.ctrl[5];
        return e.valid && is_load && e.rt != 0 && (e.rt == id_rs || e.rt == id_rt);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial m = empty_ex();

    always @(posedge rst_i) m = empty_ex();

    always @(posedge clk_i) begin
        if (rst_i) begin
            m = empty_ex();
        end else if (!stall_i) begin
            if (flush_i || model_hazard(m, int'(RegRs_i), int'(RegRt_i))) begin
                int c;
                c = (m.cnt < CNT_MAX) ? m.cnt + 1 : CNT_MAX;
                m = empty_ex();
                m.cnt = c;
            end else begin
                m.valid = 1;
                m.ctrl  = {RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i};
                m.d1 = longint'(RegData1_i); m.d2 = longint'(RegData2_i); m.imm = longint'(Imm_i);
                m.rs = int'(RegRs_i); m.rt = int'(RegRt_i); m.rd = int'(RegRd_i);
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk_i) begin
        bit hz;
        hz = model_hazard(m, int'(RegRs_i), int'(RegRt_i));
        chk("ctrl", {RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, ALUOp_o}, m.ctrl);
        chk("data1", RegData1_o, m.d1);
        chk("data2", RegData2_o, m.d2);
        chk("imm", Imm_o, m.imm);
        chk("idx", {RegRs_o, RegRt_o, RegRd_o}, {m.rs[4:0], m.rt[4:0], m.rd[4:0]});
        chk("valid", valid_o, m.valid);
        chk("bubble_cnt", bubble_cnt_o, m.cnt);
        chk("hazard", {hazard_o, PCWrite_o, IFIDWrite_o}, {hz, !hz, !hz});
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic id_set(input bit rw, input bit mr, input logic [1:0] op,
                          input logic [31:0] d1, input int rs, input int rt, input int rd);
        RegWrite_i = rw; MemToReg_i = mr; MemRead_i = mr; MemWrite_i = 0;
        ALUSrc_i = mr; RegDst_i = !mr; ALUOp_i = op;
        RegData1_i = d1; RegData2_i = d1 ^ 32'h00FF_00FF; Imm_i = {16'h0, d1[15:0]};
        RegRs_i = REG_AW'(rs); RegRt_i = REG_AW'(rt); RegRd_i = REG_AW'(rd);
    endtask

    task automatic id_rand();
        RegWrite_i = 1'($urandom); MemToReg_i = 1'($urandom); MemRead_i = 1'($urandom);
        MemWrite_i = 1'($urandom); ALUSrc_i = 1'($urandom); RegDst_i = 1'($urandom);
        ALUOp_i = 2'($urandom);
        RegData1_i = $urandom; RegData2_i = $urandom; Imm_i = $urandom;
        RegRs_i = REG_AW'($urandom_range(0, 3)); RegRt_i = REG_AW'($urandom_range(0, 3));
        RegRd_i = REG_AW'($urandom);
    endtask

    initial begin
        int c0;
        // Reset state
        #2;
        chk("rst_valid", valid_o, 0);
        chk("rst_cnt", bubble_cnt_o, 0);
        chk("rst_pcwrite", {hazard_o, PCWrite_o, IFIDWrite_o}, 3'b011);
        tick();
        rst_i = 0;

        // Reset then load
        id_set(1, 0, 2'b10, 32'h5, 3, 4, 5);
        tick();
        chk("load_rs_rt_rd", {RegRs_o, RegRt_o, RegRd_o}, {5'd3, 5'd4, 5'd5});
        chk("load_data1", RegData1_o, 32'h5);
        chk("load_aluop_rw", {ALUOp_o, RegWrite_o, valid_o, hazard_o}, 5'b10110);

        // Load-use
        id_set(1, 1, 2'b00, 32'h100, 1, 8, 0);
        tick();
        id_set(1, 0, 2'b10, 32'h77, 8, 9, 2);
        #1;
        chk("lu_hazard", {hazard_o, PCWrite_o, IFIDWrite_o}, 3'b100);
        tick();
        chk("lu_bubble", {valid_o, MemRead_o, RegRt_o, RegData1_o}, 0);
        chk("lu_cnt", bubble_cnt_o, 1);
        chk("lu_hazard_gone", hazard_o, 0);
        tick();
        chk("lu_reload", {valid_o, RegRs_o, RegData1_o}, {1'b1, 5'd8, 32'h77});

        // Zero register
        id_set(1, 1, 2'b00, 32'h200, 0, 0, 0);
        tick();
        id_set(1, 0, 2'b01, 32'h300, 0, 6, 7);
        #1;
        chk("zero_no_hazard", hazard_o, 0);
        tick();
        chk("zero_load", {valid_o, RegData1_o, RegRt_o}, {1'b1, 32'h300, 5'd6});

        // Stall priority over flush
        c0 = int'(bubble_cnt_o);
        stall_i = 1; flush_i = 1;
        repeat (3) tick();
        chk("stall_hold", {valid_o, RegData1_o, RegRt_o}, {1'b1, 32'h300, 5'd6});
        chk("stall_cnt", bubble_cnt_o, c0);
        stall_i = 0;
        tick();
        flush_i = 0;
        chk("flush_after_stall", {valid_o, bubble_cnt_o}, {1'b0, 8'(c0 + 1)});

        // Flush and hazard together
        id_set(1, 1, 2'b00, 32'h400, 1, 10, 0);
        tick();
        c0 = int'(bubble_cnt_o);
        id_set(1, 0, 2'b10, 32'h500, 10, 10, 3);
        flush_i = 1;
        #1;
        chk("fh_hazard", hazard_o, 1);
        tick();
        flush_i = 0;
        chk("fh_single", {valid_o, bubble_cnt_o}, {1'b0, 8'(c0 + 1)});

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            id_rand();
            stall_i = ($urandom_range(0, 9) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            tick();
        end
        stall_i = 0; flush_i = 0;

        // Saturation
        flush_i = 1;
        repeat (CNT_MAX + 2) tick();
        chk("sat_max", bubble_cnt_o, CNT_MAX);
        tick();
        chk("sat_hold", bubble_cnt_o, CNT_MAX);
        flush_i = 0;
        id_set(1, 1, 2'b11, 32'hDEAD_BEEF, 2, 3, 4);
        tick();
        chk("sat_load", {valid_o, RegData1_o}, {1'b1, 32'hDEAD_BEEF});

        // Async reset between edges
        #1;
        rst_i = 1;
        #1;
        chk("async_rst", {valid_o, RegData1_o, RegRt_o, MemRead_o, bubble_cnt_o}, 0);
        chk("async_rst_pc", {hazard_o, PCWrite_o, IFIDWrite_o}, 3'b011);
        #1;
        rst_i = 0;
        id_set(1, 1, 2'b00, 32'h42, 3, 3, 3);
        tick();
        chk("post_rst_load", {valid_o, RegData1_o, bubble_cnt_o}, {1'b1, 32'h42, 8'd0});
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
